// File: rtl/vbs_capture.sv
// Composite-video receiver: recovers line/frame timing from sync and writes the
// sampled 1-bpp picture byte-wise into frame RAM (3 lines packed per 128 bytes).
module vbs_capture #(
  parameter int LINE_COUNT = 313,
  parameter int HS_MIN     = 16,
  parameter int HS_MAX     = 48,
  parameter int BROAD_MIN  = 64,
  parameter int PIX_START  = 95,
  parameter int V_START    = 35,
  parameter int BYTES      = 40,
  parameter int LINES      = 192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sync,
  input  logic        pixel,
  input  logic        capture,
  output logic [12:0] wAddr,
  output logic [7:0]  wData,
  output logic        wStrobe,
  output logic        busy,
  output logic        frameDone,
  output logic        locked
);

  localparam logic [8:0]  PW_SAT_C     = 9'd511;
  localparam logic [8:0]  H_LAST_C     = 9'd511;
  localparam logic [8:0]  HS_MIN_C     = 9'(HS_MIN);
  localparam logic [8:0]  HS_MAX_C     = 9'(HS_MAX);
  localparam logic [8:0]  BROAD_C      = 9'(BROAD_MIN);
  localparam logic [8:0]  PIX_START_C  = 9'(PIX_START);
  localparam logic [8:0]  PIX_END_C    = 9'(PIX_START + 8 * BYTES);
  localparam logic [8:0]  V_START_C    = 9'(V_START);
  localparam logic [8:0]  V_PRE_C      = 9'(V_START - 1);
  localparam logic [8:0]  V_END_C      = 9'(V_START + LINES);
  localparam logic [8:0]  V_LAST_C     = 9'(V_START + LINES - 1);
  localparam logic [8:0]  VC_MAX_C     = 9'(LINE_COUNT + 8);
  localparam logic [8:0]  VC_PRE_C     = 9'(LINE_COUNT + 7);
  localparam logic [5:0]  BYTE_LAST_C  = 6'(BYTES - 1);
  localparam logic [12:0] GROUP_STEP_C = 13'(128 - 3 * BYTES + 1);

  logic [8:0]  pw_q, pw_d;
  logic [8:0]  hcount_q, hcount_d;
  logic [8:0]  vcount_q, vcount_d;
  logic        in_vsync_q, in_vsync_d;
  logic        locked_q, locked_d;
  logic        busy_q, busy_d;
  logic [7:0]  shift_q, shift_d;
  logic [5:0]  byte_cnt_q, byte_cnt_d;
  logic [1:0]  lmod3_q, lmod3_d;
  logic [12:0] addr_q, addr_d;
  logic [12:0] waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        wstrobe_q, wstrobe_d;
  logic        frame_done_q, frame_done_d;

  logic        hs_valid;
  logic        vs_start;
  logic        wrap;
  logic        frame_start;
  logic        in_window;
  logic [2:0]  bit_idx;
  logic        emit;
  logic        line_end;
  logic [7:0]  byte_next;

  always_comb begin
    pw_d         = pw_q;
    hcount_d     = hcount_q;
    vcount_d     = vcount_q;
    in_vsync_d   = in_vsync_q;
    locked_d     = locked_q;
    busy_d       = busy_q;
    shift_d      = shift_q;
    byte_cnt_d   = byte_cnt_q;
    lmod3_d      = lmod3_q;
    addr_d       = addr_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    wstrobe_d    = 1'b0;
    frame_done_d = 1'b0;

    if (sync) begin
      pw_d = 9'd0;
    end else if (pw_q != PW_SAT_C) begin
      pw_d = pw_q + 9'd1;
    end

    // pw_q holds the full pulse width during the first high cycle after the pulse
    hs_valid = sync && (pw_q >= HS_MIN_C) && (pw_q <= HS_MAX_C);
    vs_start = !sync && (pw_d == BROAD_C) && !in_vsync_q;
    wrap     = !hs_valid && (hcount_q == H_LAST_C);

    hcount_d = hs_valid ? pw_q : hcount_q + 9'd1;

    if (vs_start) begin
      vcount_d = 9'd0;
    end else if (wrap && (vcount_q != VC_MAX_C)) begin
      vcount_d = vcount_q + 9'd1;
    end

    if (vs_start) begin
      in_vsync_d = 1'b1;
    end else if (hs_valid) begin
      in_vsync_d = 1'b0;
    end

    if (hs_valid && in_vsync_q) begin
      locked_d = 1'b1;
    end
    if (!vs_start && wrap && (vcount_q >= VC_PRE_C)) begin
      locked_d = 1'b0;
    end

    frame_start = wrap && !vs_start && locked_q && (vcount_q == V_PRE_C);

    in_window = busy_q
             && (vcount_q >= V_START_C) && (vcount_q < V_END_C)
             && (hcount_q >= PIX_START_C) && (hcount_q < PIX_END_C);

    // bit position tracks hCount, so a mid-line realign re-phases the byte boundary
    bit_idx   = hcount_q[2:0] - PIX_START_C[2:0];
    byte_next = {shift_q[6:0], ~pixel};
    emit      = in_window && !vs_start && (bit_idx == 3'd7);
    line_end  = (byte_cnt_q == BYTE_LAST_C);

    if (in_window) begin
      shift_d = byte_next;
    end

    if (emit) begin
      wstrobe_d    = 1'b1;
      wdata_d      = byte_next;
      waddr_d      = addr_q;
      frame_done_d = line_end && (vcount_q == V_LAST_C);
      if (line_end) begin
        byte_cnt_d = 6'd0;
        addr_d     = addr_q + ((lmod3_q == 2'd2) ? GROUP_STEP_C : 13'd1);
        lmod3_d    = (lmod3_q == 2'd2) ? 2'd0 : lmod3_q + 2'd1;
      end else begin
        byte_cnt_d = byte_cnt_q + 6'd1;
        addr_d     = addr_q + 13'd1;
      end
    end

    if (frame_start) begin
      addr_d     = 13'd0;
      lmod3_d    = 2'd0;
      byte_cnt_d = 6'd0;
    end

    // a new vsync aborts a capture in progress without signalling completion
    if (vs_start) begin
      busy_d = 1'b0;
    end else if (frame_done_q) begin
      busy_d = 1'b0;
    end else if (frame_start) begin
      busy_d = capture;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pw_q         <= 9'd0;
      hcount_q     <= 9'd0;
      vcount_q     <= 9'd0;
      in_vsync_q   <= 1'b0;
      locked_q     <= 1'b0;
      busy_q       <= 1'b0;
      shift_q      <= 8'd0;
      byte_cnt_q   <= 6'd0;
      lmod3_q      <= 2'd0;
      addr_q       <= 13'd0;
      waddr_q      <= 13'd0;
      wdata_q      <= 8'd0;
      wstrobe_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      pw_q         <= pw_d;
      hcount_q     <= hcount_d;
      vcount_q     <= vcount_d;
      in_vsync_q   <= in_vsync_d;
      locked_q     <= locked_d;
      busy_q       <= busy_d;
      shift_q      <= shift_d;
      byte_cnt_q   <= byte_cnt_d;
      lmod3_q      <= lmod3_d;
      addr_q       <= addr_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      wstrobe_q    <= wstrobe_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign wAddr     = waddr_q;
  assign wData     = wdata_q;
  assign wStrobe   = wstrobe_q;
  assign busy      = busy_q;
  assign frameDone = frame_done_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_vbs_capture.sv
// Bench for vbs_capture: a video generator model drives sync/pixel and pushes the
// expected RAM writes into a queue that is drained as the DUT strobes them.
module tb_vbs_capture;

  // shortened frame geometry; line timing and byte packing are unchanged
  localparam int V_START   = 4;
  localparam int LINES     = 6;
  localparam int BYTES     = 40;
  localparam int PIX_START = 95;
  localparam int FR_LINES  = 12;
  localparam int FRAME_WR  = LINES * BYTES;

  logic        clk = 1'b0;
  logic        reset;
  logic        sync;
  logic        pixel;
  logic        capture;
  logic [12:0] wAddr;
  logic [7:0]  wData;
  logic        wStrobe;
  logic        busy;
  logic        frameDone;
  logic        locked;

  always #5 clk = ~clk;

  vbs_capture #(
    .LINE_COUNT (FR_LINES),
    .V_START    (V_START),
    .LINES      (LINES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sync      (sync),
    .pixel     (pixel),
    .capture   (capture),
    .wAddr     (wAddr),
    .wData     (wData),
    .wStrobe   (wStrobe),
    .busy      (busy),
    .frameDone (frameDone),
    .locked    (locked)
  );

  typedef struct packed {
    logic [12:0] a;
    logic [7:0]  d;
    logic        done;
  } wr_t;

  wr_t         exp_q[$];
  logic [12:0] wr_log[$];
  int          checks = 0;
  int          errors = 0;
  int          n_wr = 0;
  int          n_done = 0;
  bit          cap_exp = 1'b0;
  int          pix_mode = 0;
  int          glitch_line = -1;
  int          reset_line = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    wr_t e;
    if (frameDone === 1'b1) n_done++;
    if (wStrobe === 1'b1) begin
      n_wr++;
      wr_log.push_back(wAddr);
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", 32'(wAddr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("waddr", 32'(wAddr), 32'(e.a));
        chk("wdata", 32'(wData), 32'(e.d));
        chk("frame_done", 32'(frameDone), 32'(e.done));
      end
    end
  endtask

  task automatic tick(input logic s, input logic p, input logic r);
    @(negedge clk);
    monitor();
    sync  = s;
    pixel = p;
    reset = r;
  endtask

  // the receiver's hCount trails the generator count by one clock, since pulse
  // width is only known in the first high cycle; pixel for hCount h goes out at gh=h+1
  task automatic run_line(input int gl, input bit broad, input bit active_ok);
    for (int gh = 0; gh < 512; gh++) begin
      logic        s;
      logic        p;
      logic        r;
      logic [7:0]  bv;
      logic [12:0] addr;
      int          pc;
      int          row;
      int          b;
      s = broad ? (gh >= 240) : (gh >= 32);
      if (gl == glitch_line && gh >= 200 && gh < 205) s = 1'b0;
      r = (gl == reset_line && gh < 3);
      if (r) cap_exp = 1'b0;
      p = 1'b1;
      if (active_ok && gl >= V_START && gl < V_START + LINES &&
          gh >= PIX_START + 1 && gh < PIX_START + 1 + 8 * BYTES) begin
        pc   = gh - PIX_START - 1;
        row  = gl - V_START;
        b    = pc / 8;
        addr = 13'((row / 3) * 128 + (row % 3) * BYTES + b);
        bv   = (pix_mode == 0) ? addr[7:0] : (pix_mode == 1) ? 8'hFF : 8'h00;
        p    = ~bv[3'(7 - pc % 8)];
        if (cap_exp && (pc % 8 == 7))
          exp_q.push_back('{a: addr, d: bv, done: (row == LINES - 1 && b == BYTES - 1)});
      end
      tick(s, p, r);
    end
  endtask

  task automatic run_lines(input int first, input int last);
    for (int gl = first; gl <= last; gl++) run_line(gl, gl < 2, 1'b1);
  endtask

  task automatic start_frame(input bit cap, input int mode);
    capture  = cap;
    cap_exp  = cap;
    pix_mode = mode;
    n_wr     = 0;
    n_done   = 0;
    wr_log.delete();
  endtask

  task automatic frame_end_checks(input string tag, input int exp_wr, input int exp_done);
    chk({tag, "_writes"}, 32'(n_wr), 32'(exp_wr));
    chk({tag, "_done_pulses"}, 32'(n_done), 32'(exp_done));
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    sync    = 1'b1;
    pixel   = 1'b1;
    capture = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b1);
    chk("rst_waddr", 32'(wAddr), 32'd0);
    chk("rst_wdata", 32'(wData), 32'd0);
    chk("rst_wstrobe", 32'(wStrobe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_framedone", 32'(frameDone), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    tick(1'b1, 1'b1, 1'b0);

    // hsync-only lines: line timing aligns but no lock without vsync
    for (int gl = 5; gl < 8; gl++) run_line(gl, 1'b0, 1'b0);
    chk("pre_locked", 32'(locked), 32'd0);

    // full capture with address-pattern data
    start_frame(1'b1, 0);
    run_lines(0, V_START);
    chk("f1_locked", 32'(locked), 32'd1);
    chk("f1_busy", 32'(busy), 32'd1);
    run_lines(V_START + 1, FR_LINES - 1);
    frame_end_checks("f1", FRAME_WR, 1);
    chk("f1_first_addr", 32'(wr_log[0]), 32'd0);
    chk("f1_line0_last", 32'(wr_log[39]), 32'd39);
    chk("f1_line1_first", 32'(wr_log[40]), 32'd40);
    chk("f1_line2_last", 32'(wr_log[119]), 32'd119);
    chk("f1_line3_first", 32'(wr_log[120]), 32'd128);
    chk("f1_final_addr", 32'(wr_log[FRAME_WR - 1]), 32'd247);

    // short glitch mid-line plus capture dropped mid-frame
    start_frame(1'b1, 0);
    run_lines(0, 5);
    capture     = 1'b0;
    glitch_line = 6;
    run_lines(6, FR_LINES - 1);
    glitch_line = -1;
    frame_end_checks("glitch", FRAME_WR, 1);

    // reset in the middle of a capture
    start_frame(1'b1, 0);
    run_lines(0, 5);
    chk("rstmid_busy_before", 32'(busy), 32'd1);
    reset_line = 6;
    run_lines(6, 6);
    reset_line = -1;
    chk("rstmid_locked", 32'(locked), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_waddr", 32'(wAddr), 32'd0);
    run_lines(7, FR_LINES - 1);
    frame_end_checks("rstmid", 2 * BYTES, 0);
    chk("rstmid_locked_end", 32'(locked), 32'd0);

    start_frame(1'b1, 0);
    run_lines(0, FR_LINES - 1);
    frame_end_checks("recover", FRAME_WR, 1);

    // early vsync aborts a capture after line 6
    start_frame(1'b1, 0);
    run_lines(0, 6);
    chk("abort_writes_before", 32'(n_wr), 32'(3 * BYTES));
    start_frame(1'b0, 0);
    run_lines(0, 1);
    chk("abort_busy", 32'(busy), 32'd0);
    run_lines(2, FR_LINES - 1);
    frame_end_checks("nocap", 0, 0);
    chk("nocap_locked", 32'(locked), 32'd1);

    // pixel held low, then high, on the active lines
    start_frame(1'b1, 1);
    run_lines(0, FR_LINES - 1);
    frame_end_checks("all_ones", FRAME_WR, 1);

    start_frame(1'b1, 2);
    run_lines(0, FR_LINES - 1);
    frame_end_checks("all_zeros", FRAME_WR, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
